// File: rtl/watch_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : watch_mode_ctrl
//  Description : Mode controller for a watch / stopwatch / cook-timer unit.
//                Advances the active mode on btn_pedge[0], shows a timed
//                mode splash on the display, and routes the function buttons
//                to the datapath that owns the current mode.
//                Optional build macro ALARM_PREEMPT_EN: a rising cook-timer
//                alarm pre-empts the display and any button acknowledges it.
//  Revision    : 1.0  initial release
// ============================================================================
module watch_mode_ctrl #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int SPLASH_MS = 500
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic [3:0]  btn_pedge,
    input  logic [15:0] watch_value,
    input  logic [15:0] swatch_value,
    input  logic [15:0] ctimer_value,
    input  logic        ctimer_alarm,
    output logic [2:0]  watch_btn,
    output logic [2:0]  swatch_btn,
    output logic [2:0]  ctimer_btn,
    output logic [15:0] value,
    output logic [1:0]  mode,
    output logic        splash,
    output logic        alarm_clr
);

`ifdef ALARM_PREEMPT_EN
    localparam bit c_PREEMPT = 1'b1;
`else
    localparam bit c_PREEMPT = 1'b0;
`endif

    // One ms tick every c_TICK clocks; the splash lasts SPLASH_MS ticks.
    localparam int c_TICK    = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int c_PRESC_W = (c_TICK > 1) ? $clog2(c_TICK) : 1;
    localparam int c_MS      = (SPLASH_MS > 0) ? SPLASH_MS : 1;
    localparam int c_CNT_W   = (c_MS > 1) ? $clog2(c_MS) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(c_TICK - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_LAST   = c_CNT_W'(c_MS - 1);

    localparam logic [1:0] c_MODE_WATCH  = 2'd0;
    localparam logic [1:0] c_MODE_SWATCH = 2'd1;
    localparam logic [1:0] c_MODE_CTIMER = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SPLASH = 2'd1,
        ST_ALARM  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [c_PRESC_W-1:0]   presc_q, presc_d;
    logic [c_CNT_W-1:0]     cnt_q, cnt_d;
    logic                   alarm_q;
    logic                   alarm_clr_q, alarm_clr_d;
    logic                   w_alarm_rise;
    logic                   w_fwd_en;
    logic [1:0]             w_mode_next;
    logic [2:0]             w_fwd;

    // Alarm is acted on only at its rising edge, and only in the pre-empt build.
    assign w_alarm_rise = c_PREEMPT & ctimer_alarm & ~alarm_q;

    // Mode advance wraps after the cook timer; the unused code 3 recovers to watch.
    always_comb begin
        w_mode_next = c_MODE_WATCH;
        case (mode_q)
            c_MODE_WATCH:  w_mode_next = c_MODE_SWATCH;
            c_MODE_SWATCH: w_mode_next = c_MODE_CTIMER;
            default:       w_mode_next = c_MODE_WATCH;
        endcase
    end

    // State, mode and splash-timer registers.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q     <= ST_RUN;
            mode_q      <= c_MODE_WATCH;
            presc_q     <= '0;
            cnt_q       <= '0;
            alarm_q     <= 1'b0;
            alarm_clr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            presc_q     <= presc_d;
            cnt_q       <= cnt_d;
            alarm_q     <= ctimer_alarm & c_PREEMPT;
            alarm_clr_q <= alarm_clr_d;
        end
    end

    // Next-state logic; function buttons are forwarded only in an undisturbed RUN cycle.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        presc_d     = presc_q;
        cnt_d       = cnt_q;
        alarm_clr_d = 1'b0;
        w_fwd_en    = 1'b0;

        if (w_alarm_rise) begin
            state_d = ST_ALARM;
            mode_d  = c_MODE_CTIMER;
            presc_d = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (btn_pedge[0]) begin
                        state_d = ST_SPLASH;
                        mode_d  = w_mode_next;
                        presc_d = '0;
                        cnt_d   = '0;
                    end else begin
                        w_fwd_en = 1'b1;
                    end
                end
                ST_SPLASH: begin
                    if (btn_pedge[0]) begin
                        mode_d  = w_mode_next;
                        presc_d = '0;
                        cnt_d   = '0;
                    end else if (presc_q == c_PRESC_LAST) begin
                        presc_d = '0;
                        if (cnt_q == c_CNT_LAST) begin
                            state_d = ST_RUN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                ST_ALARM: begin
                    if (|btn_pedge) begin
                        alarm_clr_d = 1'b1;
                        state_d     = ST_RUN;
                        mode_d      = c_MODE_CTIMER;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Button routing and display selection are purely combinational.
    always_comb begin
        w_fwd      = w_fwd_en ? btn_pedge[3:1] : 3'b000;
        watch_btn  = (mode_q == c_MODE_WATCH)  ? w_fwd : 3'b000;
        swatch_btn = (mode_q == c_MODE_SWATCH) ? w_fwd : 3'b000;
        ctimer_btn = (mode_q == c_MODE_CTIMER) ? w_fwd : 3'b000;

        if (state_q == ST_SPLASH) begin
            value = 16'hF000 | {14'd0, mode_q};
        end else begin
            case (mode_q)
                c_MODE_SWATCH: value = swatch_value;
                c_MODE_CTIMER: value = ctimer_value;
                default:       value = watch_value;
            endcase
        end
    end

    assign mode      = mode_q;
    assign splash    = (state_q == ST_SPLASH);
    assign alarm_clr = alarm_clr_q;

endmodule
`default_nettype wire

// File: tb/tb_watch_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_watch_mode_ctrl
//  Description : Directed self-checking bench for watch_mode_ctrl
//                (CLK_HZ=4000, SPLASH_MS=3 -> 12-cycle splash).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_watch_mode_ctrl;

    localparam logic [15:0] c_WV = 16'h1234;
    localparam logic [15:0] c_SV = 16'h5678;
    localparam logic [15:0] c_CV = 16'h9ABC;

    logic        clk = 1'b0;
    logic        reset_p;
    logic [3:0]  btn_pedge;
    logic [15:0] watch_value, swatch_value, ctimer_value;
    logic        ctimer_alarm;
    logic [2:0]  watch_btn, swatch_btn, ctimer_btn;
    logic [15:0] value;
    logic [1:0]  mode;
    logic        splash;
    logic        alarm_clr;

    int total = 0;
    int bad   = 0;

    watch_mode_ctrl #(.CLK_HZ(4000), .SPLASH_MS(3)) dut (
        .clk          (clk),
        .reset_p      (reset_p),
        .btn_pedge    (btn_pedge),
        .watch_value  (watch_value),
        .swatch_value (swatch_value),
        .ctimer_value (ctimer_value),
        .ctimer_alarm (ctimer_alarm),
        .watch_btn    (watch_btn),
        .swatch_btn   (swatch_btn),
        .ctimer_btn   (ctimer_btn),
        .value        (value),
        .mode         (mode),
        .splash       (splash),
        .alarm_clr    (alarm_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to 1 ns after the next falling edge; all driving and sampling happens here.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        tick();
        reset_p   = 1'b1;
        btn_pedge = 4'b0000;
        tick();
        reset_p = 1'b0;
    endtask

    // Counts splash-high samples from the current one onward, bounded.
    task automatic count_splash(output int n);
        n = 0;
        while (splash === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset_p      = 1'b1;
        btn_pedge    = 4'b0000;
        ctimer_alarm = 1'b0;
        watch_value  = c_WV;
        swatch_value = c_SV;
        ctimer_value = c_CV;
        tick();
        tick();
        total++; if (mode !== 2'd0) begin bad++; $display("FAIL reset_mode got=%0d exp=0", mode); end
        total++; if (splash !== 1'b0) begin bad++; $display("FAIL reset_splash got=%b exp=0", splash); end
        total++; if (value !== c_WV) begin bad++; $display("FAIL reset_value got=%h exp=%h", value, c_WV); end
        total++; if (alarm_clr !== 1'b0) begin bad++; $display("FAIL reset_alarm_clr got=%b exp=0", alarm_clr); end
        total++; if ({watch_btn, swatch_btn, ctimer_btn} !== 9'd0) begin
            bad++; $display("FAIL reset_btns got=%b exp=0", {watch_btn, swatch_btn, ctimer_btn}); end
        reset_p = 1'b0;
    endtask

    task automatic test_route();
        tick();
        btn_pedge = 4'b0010;
        #1;
        total++; if (watch_btn !== 3'b001) begin bad++; $display("FAIL route_watch got=%b exp=001", watch_btn); end
        total++; if ({swatch_btn, ctimer_btn} !== 6'd0) begin
            bad++; $display("FAIL route_others got=%b exp=0", {swatch_btn, ctimer_btn}); end
        total++; if (value !== c_WV) begin bad++; $display("FAIL route_value got=%h exp=%h", value, c_WV); end
        btn_pedge = 4'b1110;
        #1;
        total++; if (watch_btn !== 3'b111) begin bad++; $display("FAIL route_watch_all got=%b exp=111", watch_btn); end
        tick();
        btn_pedge = 4'b0000;
        #1;
        total++; if (mode !== 2'd0) begin bad++; $display("FAIL route_mode_kept got=%0d exp=0", mode); end
    endtask

    task automatic test_splash();
        int n;
        tick();
        btn_pedge = 4'b0001;
        tick();
        btn_pedge = 4'b0000;
        #1;
        total++; if (mode !== 2'd1) begin bad++; $display("FAIL splash_mode got=%0d exp=1", mode); end
        total++; if (value !== 16'hF001) begin bad++; $display("FAIL splash_value got=%h exp=f001", value); end
        total++; if (swatch_btn !== 3'b000) begin bad++; $display("FAIL splash_btn got=%b exp=0", swatch_btn); end
        count_splash(n);
        total++; if (n !== 12) begin bad++; $display("FAIL splash_len got=%0d exp=12", n); end
        total++; if (value !== c_SV) begin bad++; $display("FAIL splash_after_value got=%h exp=%h", value, c_SV); end
        btn_pedge = 4'b0100;
        #1;
        total++; if ({watch_btn, swatch_btn, ctimer_btn} !== 9'b000_010_000) begin
            bad++; $display("FAIL route_swatch got=%b exp=000010000", {watch_btn, swatch_btn, ctimer_btn}); end
        tick();
        btn_pedge = 4'b0000;
    endtask

    task automatic test_sequence();
        int n;
        logic [1:0] exp_mode [3];
        exp_mode[0] = 2'd1;
        exp_mode[1] = 2'd2;
        exp_mode[2] = 2'd0;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            btn_pedge = 4'b0001;
            tick();
            btn_pedge = 4'b0000;
            #1;
            count_splash(n);
            total++; if (mode !== exp_mode[i]) begin
                bad++; $display("FAIL seq_mode[%0d] got=%0d exp=%0d", i, mode, exp_mode[i]); end
        end
    endtask

    task automatic test_restart();
        int n;
        tick();
        btn_pedge = 4'b0001;
        tick();
        btn_pedge = 4'b0000;
        repeat (7) tick();
        btn_pedge = 4'b0001;
        tick();
        btn_pedge = 4'b0000;
        #1;
        total++; if (mode !== 2'd2) begin bad++; $display("FAIL restart_mode got=%0d exp=2", mode); end
        total++; if (value !== 16'hF002) begin bad++; $display("FAIL restart_value got=%h exp=f002", value); end
        n = 0;
        while (splash === 1'b1 && n < 40) begin
            n++;
            if (n == 3) begin
                btn_pedge = 4'b0100;
                #1;
                total++; if ({watch_btn, swatch_btn, ctimer_btn} !== 9'd0) begin
                    bad++; $display("FAIL drop_in_splash got=%b exp=0", {watch_btn, swatch_btn, ctimer_btn}); end
            end
            tick();
            btn_pedge = 4'b0000;
        end
        total++; if (n !== 12) begin bad++; $display("FAIL restart_len got=%0d exp=12", n); end
        total++; if (value !== c_CV) begin bad++; $display("FAIL restart_after_value got=%h exp=%h", value, c_CV); end
        total++; if (ctimer_btn !== 3'b000) begin bad++; $display("FAIL restart_no_queue got=%b exp=0", ctimer_btn); end
    endtask

    task automatic test_back_to_back();
        int n;
        apply_reset();
        tick();
        btn_pedge = 4'b1001;
        #1;
        total++; if ({watch_btn, swatch_btn} !== 6'd0) begin
            bad++; $display("FAIL same_cycle_btn got=%b exp=0", {watch_btn, swatch_btn}); end
        tick();
        btn_pedge = 4'b0000;
        #1;
        total++; if (mode !== 2'd1) begin bad++; $display("FAIL same_cycle_mode got=%0d exp=1", mode); end
        total++; if (splash !== 1'b1) begin bad++; $display("FAIL same_cycle_splash got=%b exp=1", splash); end
        total++; if (swatch_btn !== 3'b000) begin bad++; $display("FAIL same_cycle_swatch got=%b exp=0", swatch_btn); end
        count_splash(n);
    endtask

    task automatic test_reset_mid_splash();
        tick();
        btn_pedge = 4'b0001;
        tick();
        btn_pedge = 4'b0000;
        repeat (3) tick();
        reset_p = 1'b1;
        #1;
        total++; if (mode !== 2'd0) begin bad++; $display("FAIL midreset_mode got=%0d exp=0", mode); end
        total++; if (splash !== 1'b0) begin bad++; $display("FAIL midreset_splash got=%b exp=0", splash); end
        total++; if (value !== c_WV) begin bad++; $display("FAIL midreset_value got=%h exp=%h", value, c_WV); end
        tick();
        reset_p = 1'b0;
    endtask

`ifdef ALARM_PREEMPT_EN
    task automatic test_alarm();
        apply_reset();
        tick();
        ctimer_alarm = 1'b1;
        tick();
        total++; if (mode !== 2'd2) begin bad++; $display("FAIL alarm_mode got=%0d exp=2", mode); end
        total++; if (value !== c_CV) begin bad++; $display("FAIL alarm_value got=%h exp=%h", value, c_CV); end
        btn_pedge = 4'b1000;
        #1;
        total++; if (ctimer_btn !== 3'b000) begin bad++; $display("FAIL alarm_btn_fwd got=%b exp=0", ctimer_btn); end
        tick();
        btn_pedge = 4'b0000;
        #1;
        total++; if (alarm_clr !== 1'b1) begin bad++; $display("FAIL alarm_clr_pulse got=%b exp=1", alarm_clr); end
        total++; if (mode !== 2'd2) begin bad++; $display("FAIL alarm_clr_mode got=%0d exp=2", mode); end
        tick();
        total++; if (alarm_clr !== 1'b0) begin bad++; $display("FAIL alarm_clr_once got=%b exp=0", alarm_clr); end
        btn_pedge = 4'b1000;
        #1;
        total++; if (ctimer_btn !== 3'b100) begin bad++; $display("FAIL alarm_then_run got=%b exp=100", ctimer_btn); end
        tick();
        btn_pedge    = 4'b0000;
        ctimer_alarm = 1'b0;
        // Rising alarm during a splash wins over a same-cycle mode advance.
        apply_reset();
        tick();
        btn_pedge = 4'b0001;
        tick();
        btn_pedge    = 4'b0001;
        ctimer_alarm = 1'b1;
        tick();
        btn_pedge = 4'b0000;
        #1;
        total++; if (mode !== 2'd2) begin bad++; $display("FAIL preempt_mode got=%0d exp=2", mode); end
        total++; if (splash !== 1'b0) begin bad++; $display("FAIL preempt_splash got=%b exp=0", splash); end
        total++; if (value !== c_CV) begin bad++; $display("FAIL preempt_value got=%h exp=%h", value, c_CV); end
        reset_p = 1'b1;
        #1;
        total++; if ({mode, alarm_clr} !== 3'b000) begin
            bad++; $display("FAIL alarm_midreset got=%b exp=000", {mode, alarm_clr}); end
        tick();
        reset_p      = 1'b0;
        ctimer_alarm = 1'b0;
    endtask
`else
    task automatic test_alarm();
        apply_reset();
        tick();
        ctimer_alarm = 1'b1;
        tick();
        total++; if (mode !== 2'd0) begin bad++; $display("FAIL alarm_ignored_mode got=%0d exp=0", mode); end
        total++; if (value !== c_WV) begin bad++; $display("FAIL alarm_ignored_value got=%h exp=%h", value, c_WV); end
        btn_pedge = 4'b0010;
        #1;
        total++; if (watch_btn !== 3'b001) begin bad++; $display("FAIL alarm_ignored_btn got=%b exp=001", watch_btn); end
        tick();
        btn_pedge = 4'b0000;
        #1;
        total++; if (alarm_clr !== 1'b0) begin bad++; $display("FAIL alarm_clr_tied got=%b exp=0", alarm_clr); end
        ctimer_alarm = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_route();
        test_splash();
        test_sequence();
        test_restart();
        test_back_to_back();
        test_reset_mid_splash();
        test_alarm();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/watch_mode_ctrl.md
WATCH_MODE_CTRL -- requirements
Module: watch_mode_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter SPLASH_MS, default 500, mode-splash duration in milliseconds.
REQ-003 clk  input  1  system clock; all state updates on posedge clk.
REQ-004 reset_p  input  1  asynchronous, active-high reset.
REQ-005 btn_pedge  input  4  one-cycle button edge pulses; [0] is mode advance, [3:1] are function buttons.
REQ-006 watch_value, swatch_value, ctimer_value  input  16 each  BCD display words from the clock, stopwatch and cook-timer datapaths.
REQ-007 ctimer_alarm  input  1  level, high while the cook timer is expired.
REQ-008 watch_btn, swatch_btn, ctimer_btn  output  3 each  routed copies of btn_pedge[3:1], bit-aligned (btn_pedge[1] maps to [0]).
REQ-009 value  output  16  display word to the FND driver.
REQ-010 mode  output  2  active mode: 0 watch, 1 stopwatch, 2 cook timer; 3 never driven.
REQ-011 splash  output  1  high while the mode-splash is displayed.
REQ-012 alarm_clr  output  1  one-cycle pulse acknowledging the cook-timer alarm.

Function
REQ-013 FSM states: RUN, SPLASH, ALARM; mode is a separate 2-bit register.
REQ-014 In RUN, a btn_pedge[0] pulse advances mode 0->1->2->0 on the next edge, enters SPLASH, and clears the ms prescaler and splash counter.
REQ-015 In SPLASH, a further btn_pedge[0] pulse advances mode again and restarts the splash timing from zero.
REQ-016 The ms prescaler counts CLK_HZ/1000 clocks per tick; SPLASH lasts exactly SPLASH_MS*CLK_HZ/1000 cycles, then returns to RUN.
REQ-017 Routing is combinational with zero latency: in RUN only, the *_btn bus selected by mode equals btn_pedge[3:1]; all other *_btn buses are 0.
REQ-018 In SPLASH and ALARM all *_btn outputs are 0, and function-button pulses are dropped, not queued.
REQ-019 When btn_pedge[0] and any of btn_pedge[3:1] arrive in the same cycle, the mode change wins and the function pulses are dropped.
REQ-020 value = watch_value, swatch_value or ctimer_value according to mode in RUN and ALARM; in SPLASH, value = 16'hF000 | mode.
REQ-021 splash is high exactly when the state is SPLASH.
REQ-022 Datapaths keep running regardless of mode; the controller only gates buttons and the display.

Reset
REQ-023 Under reset_p: state=RUN, mode=0, prescaler and splash counter=0, alarm edge register=0, splash=0, alarm_clr=0, all *_btn=0, value=watch_value.
REQ-024 Reset asserted mid-SPLASH or mid-ALARM aborts immediately to the reset state with no alarm_clr pulse.

Configuration
REQ-025 Macro ALARM_PREEMPT_EN, defined: a rising edge of ctimer_alarm, from any state, forces mode=2 and state=ALARM, and cancels any splash; this takes priority over a same-cycle btn_pedge[0].
REQ-026 With ALARM_PREEMPT_EN defined, in ALARM any btn_pedge[3:0] pulse produces alarm_clr=1 for one cycle and the state returns to RUN with mode=2; that pulse is not forwarded.
REQ-027 With ALARM_PREEMPT_EN undefined: ctimer_alarm is ignored, ALARM is unreachable, and alarm_clr is tied to 0.

Verification
REQ-028 Reset, then btn_pedge=4'b0010 -> watch_btn=3'b001 in the same cycle; swatch_btn=ctimer_btn=0; value=watch_value.
REQ-029 With CLK_HZ=4000 and SPLASH_MS=3, pulse btn_pedge[0] -> mode=1, splash high for exactly 12 cycles, value=16'hF001, then value=swatch_value.
REQ-030 Pulse btn_pedge[0] three times, each separated by a completed splash -> mode sequence 1, 2, 0.
REQ-031 Pulse btn_pedge[0] at splash cycle 8, then pulse btn_pedge[2] during the splash -> mode=2, splash lasts 12 more cycles, btn_pedge[2] is dropped (all *_btn=0).
REQ-032 btn_pedge=4'b1001 in RUN at mode 0 -> mode=1 and splash start; watch_btn and swatch_btn stay 0.
REQ-033 With ALARM_PREEMPT_EN defined: in mode 0, raise ctimer_alarm -> mode=2, value=ctimer_value; then pulse btn_pedge[3] -> alarm_clr pulses once and ctimer_btn stays 0.
